pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//   Next-generation branch/PC-select stage of the RISC CPU: replaces the 2:1 next-PC mux with a
//   registered, parametrised PC unit. Resolves BEQ/BNE, jump and exception redirects by fixed
//   priority. Holds a redirect across pipeline stalls. Drives a timed flush of wrong-path
//   instructions. Sits between fetch (consumes pc) and execute (drives branch/jump/exception).
// PARAMETERS
//   WIDTH         32     address/operand width in bits
//   RESET_PC      0      pc value loaded on reset
//   INC           4      sequential pc increment
//   EXC_VEC       'h100  exception vector address
//   FLUSH_CYCLES  2      flush pulse length in cycles after a redirect; 0 disables flush
// PORTS
//   clk              in   1      single clock, rising edge
//   rst              in   1      synchronous reset, active-high
//   stall            in   1      freeze pc, flush counter and state
//   br_en            in   1      branch instruction valid in execute
//   br_mode          in   1      0=BEQ (taken if br_a==br_b), 1=BNE (taken if br_a!=br_b)
//   br_a, br_b       in   WIDTH  branch compare operands
//   br_target        in   WIDTH  branch target address
//   jmp_en           in   1      unconditional jump valid
//   jmp_target       in   WIDTH  jump target address
//   exc              in   1      exception request
//   pc               out  WIDTH  current fetch address (registered)
//   flush            out  1      kill wrong-path instructions in fetch/decode (registered)
//   redirect_pending out  1      redirect latched during stall, not yet applied (registered)
// BEHAVIOUR
//   Reset: on the rising edge with rst=1:
//     - pc=RESET_PC, flush=0, redirect_pending=0, state=RUN, flush counter=0.
//     - rst overrides all other inputs, including mid-flush and mid-hold.
//   Request decode (combinational), priority exc > jmp_en > taken branch:
//     - target = EXC_VEC / jmp_target / br_target; req=1 if any of the three is active.
//     - In state FLUSH, jmp_en and br_en are ignored (wrong path); only exc is honoured.
//   States:
//     RUN:
//       - stall=0, req=1: pc<=target, load counter=FLUSH_CYCLES, go FLUSH (stay RUN if FLUSH_CYCLES=0).
//       - stall=0, req=0: pc<=pc+INC, modulo 2^WIDTH (wraps, no carry out).
//       - stall=1, req=1: pc holds, latch target, redirect_pending<=1, go HOLD.
//       - stall=1, req=0: all state holds.
//     HOLD:
//       - stall=1: pc holds. A new exc overwrites the latched target with EXC_VEC; jmp/branch
//         requests are ignored.
//       - stall=0: pc<=latched target (or EXC_VEC if exc this cycle), redirect_pending<=0,
//         load counter, go FLUSH.
//     FLUSH:
//       - flush=1 while counter!=0.
//       - stall=0: counter decrements and pc<=pc+INC.
//       - exc with stall=0: pc<=EXC_VEC, counter reloads to FLUSH_CYCLES.
//       - stall=1: counter and pc hold; exc goes to HOLD as in RUN.
//       - Counter reaching 0: go RUN.
//   Latency:
//     - Redirect visible on pc 1 cycle after the request (or after stall release).
//     - flush rises in the same cycle pc shows the target and lasts FLUSH_CYCLES unstalled cycles.
//   Width rules: br_a/br_b compared over full WIDTH; all adders truncate to WIDTH.
// TESTING
//   1. Sequential fetch: rst 1 cycle, then idle -> pc 0,4,8,C; flush=0, redirect_pending=0.
//   2. BEQ taken: at pc=8, br_en=1, br_mode=0, a=b=5, br_target=0x40
//      -> pc=0x40 next cycle, flush=1 for 2 cycles, then pc=0x44,0x48.
//   3. BNE not taken: br_mode=1, a=b=7, br_target=0x40 -> no redirect, pc+=4, flush stays 0.
//   4. Stalled jump: stall=1 for 3 cycles with jmp_en, jmp_target=0x80
//      -> pc frozen, redirect_pending=1; stall drops -> pc=0x80, pending=0, flush 2 cycles.
//   5. Priority: exc+jmp_en same cycle -> pc=0x100. jmp_en during the following flush -> ignored.
//   6. Boundaries:
//      - pc=0xFFFFFFFC unstalled -> pc=0x0.
//      - rst asserted in the 1st flush cycle -> next cycle pc=0, flush=0, redirect_pending=0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Registered next-PC unit: sequential fetch, BEQ/BNE/jump/exception redirects by fixed priority,
// redirect hold across stalls, and a counted flush pulse after every applied redirect.
module pc_redirect_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_PC     = '0,
  parameter int unsigned       INC          = 4,
  parameter logic [WIDTH-1:0]  EXC_VEC      = 'h100,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_en,
  input  logic             br_mode,
  input  logic [WIDTH-1:0] br_a,
  input  logic [WIDTH-1:0] br_b,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_en,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic             flush,
  output logic             redirect_pending
);

  localparam int unsigned CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             pend_q, pend_d;

  logic             br_taken;
  logic             req;
  logic [WIDTH-1:0] target;

  always_comb begin
    br_taken = br_en && (br_mode ? (br_a != br_b) : (br_a == br_b));
    // Jump/branch requests are only meaningful on the correct path, i.e. in RUN.
    req    = 1'b0;
    target = '0;
    if (exc) begin
      req    = 1'b1;
      target = EXC_VEC;
    end else if (state_q == RUN && jmp_en) begin
      req    = 1'b1;
      target = jmp_target;
    end else if (state_q == RUN && br_taken) begin
      req    = 1'b1;
      target = br_target;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (req) begin
            pc_d  = target;
            cnt_d = CNT_LOAD;
          end else begin
            pc_d = pc_q + WIDTH'(INC);
          end
          state_d = (cnt_d != '0) ? FLUSH : RUN;
        end else if (req) begin
          tgt_d   = target;
          pend_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          if (exc) tgt_d = EXC_VEC;
        end else begin
          pc_d    = exc ? EXC_VEC : tgt_q;
          pend_d  = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = (cnt_d != '0) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if (!stall) begin
          if (exc) begin
            pc_d  = EXC_VEC;
            cnt_d = CNT_LOAD;
          end else begin
            pc_d  = pc_q + WIDTH'(INC);
            cnt_d = cnt_q - CW'(1);
          end
          state_d = (cnt_d != '0) ? FLUSH : RUN;
        end else if (exc) begin
          tgt_d   = EXC_VEC;
          pend_d  = 1'b1;
          state_d = HOLD;
        end
      end
      default: state_d = RUN;
    endcase
    flush_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      pend_q  <= pend_d;
    end
  end

  assign pc               = pc_q;
  assign flush            = flush_q;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed scenarios plus a randomized run against a behavioural model.
module tb_pc_redirect_unit;

  localparam int unsigned FC  = 2;
  localparam logic [31:0] EXC = 32'h100;

  logic        clk = 1'b0;
  logic        rst, stall, br_en, br_mode, jmp_en, exc;
  logic [31:0] br_a, br_b, br_target, jmp_target;
  logic [31:0] pc;
  logic        flush, redirect_pending;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc;
  int          m_left;
  bit          m_pend;
  logic [31:0] m_tgt;

  pc_redirect_unit #(
    .WIDTH(32), .RESET_PC(32'h0), .INC(4), .EXC_VEC(EXC), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_en(br_en), .br_mode(br_mode),
    .br_a(br_a), .br_b(br_b), .br_target(br_target), .jmp_en(jmp_en),
    .jmp_target(jmp_target), .exc(exc), .pc(pc), .flush(flush),
    .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  // Behavioural model: a redirect is "pending" while stalled, otherwise it is applied at once
  // and opens a window of FC wrong-path cycles in which only exceptions are accepted.
  task automatic model_update();
    bit          correct_path, taken, have;
    logic [31:0] t;
    if (rst) begin
      m_pc = 32'h0; m_left = 0; m_pend = 0; m_tgt = 32'h0;
      return;
    end
    correct_path = !m_pend && m_left == 0;
    taken = br_en && ((br_a == br_b) == !br_mode);
    have = 1'b1;
    if (exc) t = EXC;
    else if (correct_path && jmp_en) t = jmp_target;
    else if (correct_path && taken) t = br_target;
    else begin have = 1'b0; t = 32'h0; end
    if (stall) begin
      if (have) begin m_pend = 1; m_tgt = t; end
    end else if (m_pend) begin
      m_pc = exc ? EXC : m_tgt; m_pend = 0; m_left = FC;
    end else if (have) begin
      m_pc = t; m_left = FC;
    end else begin
      m_pc = m_pc + 32'd4;
      if (m_left > 0) m_left--;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit be, input bit bm,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] bt,
                      input bit je, input logic [31:0] jt, input bit ex);
    rst = r; stall = s; br_en = be; br_mode = bm; br_a = a; br_b = b; br_target = bt;
    jmp_en = je; jmp_target = jt; exc = ex;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", redirect_pending); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      idle();
      exp_pc = 32'(i * 4);
      checks++; if (pc !== exp_pc || flush !== 1'b0 || redirect_pending !== 1'b0) begin
        failures++; $display("FAIL seq_fetch[%0d] got pc=%h fl=%b pd=%b exp pc=%h fl=0 pd=0", i, pc, flush, redirect_pending, exp_pc);
      end
    end
  endtask

  task automatic test_beq_taken();
    logic [31:0] exp_pc [3] = '{32'h40, 32'h44, 32'h48};
    bit          exp_fl [3] = '{1'b1, 1'b1, 1'b0};
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    checks++; if (pc !== 32'h8) begin failures++; $display("FAIL beq_setup got=%h exp=8", pc); end
    step(0, 0, 1, 0, 5, 5, 32'h40, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) idle();
      checks++; if (pc !== exp_pc[i] || flush !== exp_fl[i]) begin
        failures++; $display("FAIL beq_taken[%0d] got pc=%h fl=%b exp pc=%h fl=%b", i, pc, flush, exp_pc[i], exp_fl[i]);
      end
    end
  endtask

  task automatic test_bne_not_taken();
    step(0, 0, 1, 1, 7, 7, 32'h40, 0, 0, 0);
    checks++; if (pc !== 32'h4C || flush !== 1'b0) begin
      failures++; $display("FAIL bne_not_taken got pc=%h fl=%b exp pc=4c fl=0", pc, flush);
    end
  endtask

  task automatic test_stalled_jump();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0, 0, 1, 32'h80, 0);
      checks++; if (pc !== 32'h4C || redirect_pending !== 1'b1) begin
        failures++; $display("FAIL stall_jmp_hold[%0d] got pc=%h pd=%b exp pc=4c pd=1", i, pc, redirect_pending);
      end
    end
    idle();
    checks++; if (pc !== 32'h80 || redirect_pending !== 1'b0 || flush !== 1'b1) begin
      failures++; $display("FAIL stall_jmp_release got pc=%h pd=%b fl=%b exp pc=80 pd=0 fl=1", pc, redirect_pending, flush);
    end
    idle();
    checks++; if (pc !== 32'h84 || flush !== 1'b1) begin failures++; $display("FAIL stall_jmp_fl2 got pc=%h fl=%b exp pc=84 fl=1", pc, flush); end
    idle();
    checks++; if (pc !== 32'h88 || flush !== 1'b0) begin failures++; $display("FAIL stall_jmp_end got pc=%h fl=%b exp pc=88 fl=0", pc, flush); end
  endtask

  task automatic test_priority();
    step(0, 0, 1, 0, 1, 1, 32'h500, 1, 32'h200, 1);
    checks++; if (pc !== 32'h100 || flush !== 1'b1) begin failures++; $display("FAIL prio_exc got pc=%h fl=%b exp pc=100 fl=1", pc, flush); end
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0);
    checks++; if (pc !== 32'h104) begin failures++; $display("FAIL prio_jmp_in_flush got pc=%h exp=104", pc); end
    idle();
    checks++; if (pc !== 32'h108 || flush !== 1'b0) begin failures++; $display("FAIL prio_after got pc=%h fl=%b exp pc=108 fl=0", pc, flush); end
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF4, 0);
    idle(); idle();
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc); end
    idle();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", pc); end
  endtask

  task automatic test_reset_mid_flush();
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0);
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rstflush_setup got fl=%b exp=1", flush); end
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h300, 1);
    checks++; if (pc !== 32'h0 || flush !== 1'b0 || redirect_pending !== 1'b0) begin
      failures++; $display("FAIL rst_mid_flush got pc=%h fl=%b pd=%b exp 0/0/0", pc, flush, redirect_pending);
    end
    step(0, 1, 0, 0, 0, 0, 0, 1, 32'h300, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h0 || redirect_pending !== 1'b0) begin
      failures++; $display("FAIL rst_mid_hold got pc=%h pd=%b exp 0/0", pc, redirect_pending);
    end
  endtask

  task automatic test_random();
    bit r, s, be, bm, je, ex;
    logic [31:0] a, b, bt, jt;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 2) == 0);
      be = ($urandom_range(0, 2) == 0);
      bm = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 2));
      b  = 32'($urandom_range(0, 2));
      bt = {$urandom} & 32'hFFFF_FFFC;
      je = ($urandom_range(0, 4) == 0);
      jt = {$urandom} & 32'hFFFF_FFFC;
      ex = ($urandom_range(0, 11) == 0);
      step(r, s, be, bm, a, b, bt, je, jt, ex);
      checks++; if (pc !== m_pc || flush !== (m_left > 0) || redirect_pending !== m_pend) begin
        failures++;
        $display("FAIL random[%0d] got pc=%h fl=%b pd=%b exp pc=%h fl=%b pd=%b",
                 i, pc, flush, redirect_pending, m_pc, (m_left > 0), m_pend);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_en = 1'b0; br_mode = 1'b0; br_a = '0; br_b = '0;
    br_target = '0; jmp_en = 1'b0; jmp_target = '0; exc = 1'b0;
    m_pc = '0; m_left = 0; m_pend = 0; m_tgt = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_beq_taken();
    test_bne_not_taken();
    test_stalled_jump();
    test_priority();
    test_wrap();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
